// File: rtl/cook_timer_fsm_if.sv
// Button/interlock inputs and display/drive outputs of the microwave cook sequencer.
// The controller drives the buttons and door level; the sequencer drives the rest.
interface cook_timer_fsm_if;
   logic        btn_start;
   logic        btn_stop;
   logic        btn_add;
   logic        door_open;
   logic        run;
   logic        done_beep;
   logic [12:0] remain_sec;
   logic [1:0]  state;

   modport master (
      output btn_start, btn_stop, btn_add, door_open,
      input  run, done_beep, remain_sec, state
   );

   modport slave (
      input  btn_start, btn_stop, btn_add, door_open,
      output run, done_beep, remain_sec, state
   );
endinterface

// File: rtl/cook_timer_fsm.sv
// Microwave cook sequencer: seconds countdown with start/stop/add buttons, door
// interlock, and a timed completion beep. Drives the motor PWM stage run enable.
module cook_timer_fsm #(
   parameter int TICK_DIV = 100000000,
   parameter int ADD_SEC  = 30,
   parameter int MAX_SEC  = 5999,
   parameter int DONE_SEC = 3
) (
   input  logic            clk,
   input  logic            rst,
   cook_timer_fsm_if.slave bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (DONE_SEC > 1) ? $clog2(DONE_SEC) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [12:0]     remain_q, remain_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
   logic            run_q, run_d;
   logic            beep_q, beep_d;
   logic            timed;
   logic            sec_tick;

   // Sum is formed in 14 bits so a large remain_sec plus ADD_SEC cannot wrap.
   function automatic logic [12:0] sat_sec(input logic [13:0] sum);
      if (sum > 14'(MAX_SEC)) return 13'(MAX_SEC);
      return sum[12:0];
   endfunction

   always_comb begin
      state_d    = state_q;
      remain_d   = remain_q;
      presc_d    = presc_q;
      beep_cnt_d = beep_cnt_q;
      timed      = (state_q == RUN) || (state_q == DONE);
      sec_tick   = timed && (presc_q == PW'(TICK_DIV - 1));

      case (state_q)
         IDLE: begin
            if (bus.btn_stop) begin
               remain_d = '0;
            end else if (bus.btn_start) begin
               if ((remain_q != '0) && !bus.door_open) state_d = RUN;
            end else if (bus.btn_add) begin
               remain_d = sat_sec({1'b0, remain_q} + 14'(ADD_SEC));
            end
         end
         RUN: begin
            if (bus.door_open || bus.btn_stop) begin
               state_d = PAUSE;
            end else if (sec_tick) begin
               if (bus.btn_add) begin
                  remain_d = sat_sec({1'b0, remain_q} + 14'(ADD_SEC) - 14'd1);
               end else if (remain_q == 13'd1) begin
                  remain_d = '0;
                  state_d  = DONE;
               end else begin
                  remain_d = remain_q - 13'd1;
               end
            end else if (bus.btn_add) begin
               remain_d = sat_sec({1'b0, remain_q} + 14'(ADD_SEC));
            end
         end
         PAUSE: begin
            if (bus.btn_stop) begin
               remain_d = '0;
               state_d  = IDLE;
            end else if (bus.btn_start) begin
               if (!bus.door_open) state_d = RUN;
            end else if (bus.btn_add) begin
               remain_d = sat_sec({1'b0, remain_q} + 14'(ADD_SEC));
            end
         end
         DONE: begin
            if (bus.door_open || bus.btn_stop) begin
               state_d = IDLE;
            end else if (sec_tick) begin
               if (beep_cnt_q == BW'(DONE_SEC - 1)) state_d = IDLE;
               else beep_cnt_d = beep_cnt_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Any transition restarts the second timer so the first tick is a full second away.
      if ((state_d != state_q) || !timed) begin
         presc_d    = '0;
         beep_cnt_d = '0;
      end else begin
         presc_d = sec_tick ? '0 : presc_q + PW'(1);
      end

      run_d  = (state_d == RUN) && !bus.door_open;
      beep_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         remain_q   <= '0;
         presc_q    <= '0;
         beep_cnt_q <= '0;
         run_q      <= 1'b0;
         beep_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         remain_q   <= remain_d;
         presc_q    <= presc_d;
         beep_cnt_q <= beep_cnt_d;
         run_q      <= run_d;
         beep_q     <= beep_d;
      end
   end

   assign bus.run        = run_q;
   assign bus.done_beep  = beep_q;
   assign bus.remain_sec = remain_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_cook_timer_fsm.sv
// Bench for cook_timer_fsm: directed scenarios then random buttons/door/reset,
// all compared every cycle against a behavioural model of the cook sequencer.
module tb_cook_timer_fsm;

   localparam int TD  = 10;
   localparam int ADD = 30;
   localparam int MAXS = 90;
   localparam int DS  = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   cook_timer_fsm_if bus ();

   cook_timer_fsm #(
      .TICK_DIV(TD),
      .ADD_SEC (ADD),
      .MAX_SEC (MAXS),
      .DONE_SEC(DS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: 0=IDLE 1=RUN 2=PAUSE 3=DONE, cycles spent in current timed state, beeps heard.
   int m_state, m_rem, m_cycles, m_beeps;
   bit m_run, m_beep;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAXS) ? MAXS : v;
   endfunction

   task automatic model_update(input bit r, input bit st, input bit sp, input bit ad, input bit dr);
      int  ns, nr;
      bit  tick;
      if (r) begin
         m_state = 0; m_rem = 0; m_cycles = 0; m_beeps = 0; m_run = 0; m_beep = 0;
         return;
      end
      tick = (m_state == 1 || m_state == 3) && ((m_cycles + 1) % TD == 0);
      ns = m_state;
      nr = m_rem;
      case (m_state)
         0: if (sp) nr = 0;
            else if (st) begin if (m_rem > 0 && !dr) ns = 1; end
            else if (ad) nr = sat(m_rem + ADD);
         1: if (dr || sp) ns = 2;
            else if (tick) begin
               if (ad) nr = sat(m_rem - 1 + ADD);
               else if (m_rem == 1) begin nr = 0; ns = 3; end
               else nr = m_rem - 1;
            end else if (ad) nr = sat(m_rem + ADD);
         2: if (sp) begin nr = 0; ns = 0; end
            else if (st) begin if (!dr) ns = 1; end
            else if (ad) nr = sat(m_rem + ADD);
         default: if (dr || sp) ns = 0;
            else if (tick) begin
               if (m_beeps + 1 >= DS) ns = 0;
               else m_beeps++;
            end
      endcase
      if (ns != m_state) begin
         m_cycles = 0;
         m_beeps  = 0;
      end else if (ns == 1 || ns == 3) begin
         m_cycles++;
      end
      m_state = ns;
      m_rem   = nr;
      m_run   = (ns == 1) && !dr;
      m_beep  = (ns == 3);
   endtask

   task automatic step();
      @(posedge clk);
      model_update(rst, bus.btn_start, bus.btn_stop, bus.btn_add, bus.door_open);
      #1;
      chk("state", int'(bus.state), m_state);
      chk("remain_sec", int'(bus.remain_sec), m_rem);
      chk("run", int'(bus.run), int'(m_run));
      chk("done_beep", int'(bus.done_beep), int'(m_beep));
      chk("inv_run_only_in_run", int'(bus.run && bus.state != 2'd1), 0);
      chk("inv_max", int'(bus.remain_sec > 13'(MAXS)), 0);
      bus.btn_start = 1'b0;
      bus.btn_stop  = 1'b0;
      bus.btn_add   = 1'b0;
   endtask

   task automatic press(input int which);
      if (which == 0) bus.btn_start = 1'b1;
      else if (which == 1) bus.btn_stop = 1'b1;
      else bus.btn_add = 1'b1;
      step();
   endtask

   localparam int START = 0, STOP = 1, ADDB = 2;

   initial begin
      n_checks = 0;
      n_errors = 0;
      bus.btn_start = 1'b0;
      bus.btn_stop  = 1'b0;
      bus.btn_add   = 1'b0;
      bus.door_open = 1'b0;
      rst = 1'b1;
      m_state = 0; m_rem = 0; m_cycles = 0; m_beeps = 0; m_run = 0; m_beep = 0;
      step();
      step();
      rst = 1'b0;
      chk("reset_state", int'(bus.state), 0);
      chk("reset_remain", int'(bus.remain_sec), 0);

      // Full cook cycle: 60 s, countdown, done beep, back to idle.
      press(ADDB); press(ADDB); press(START);
      chk("t1_remain60", int'(bus.remain_sec), 60);
      chk("t1_run", int'(bus.run), 1);
      repeat (10) step();
      chk("t1_remain59", int'(bus.remain_sec), 59);
      repeat (590) step();
      chk("t1_done_state", int'(bus.state), 3);
      chk("t1_done_run", int'(bus.run), 0);
      chk("t1_done_beep", int'(bus.done_beep), 1);
      repeat (19) step();
      chk("t1_beep_held", int'(bus.done_beep), 1);
      step();
      chk("t1_idle", int'(bus.state), 0);
      chk("t1_beep_off", int'(bus.done_beep), 0);
      chk("t1_remain0", int'(bus.remain_sec), 0);

      // Add saturation and start with zero time.
      press(ADDB); chk("t2_add30", int'(bus.remain_sec), 30);
      press(ADDB); chk("t2_add60", int'(bus.remain_sec), 60);
      press(ADDB); chk("t2_add90", int'(bus.remain_sec), 90);
      press(ADDB); chk("t2_sat90", int'(bus.remain_sec), 90);
      press(STOP); chk("t2_stop_clear", int'(bus.remain_sec), 0);
      press(START);
      chk("t2_start_zero_state", int'(bus.state), 0);
      chk("t2_start_zero_run", int'(bus.run), 0);

      // Door interlock pause and resume.
      press(ADDB); press(ADDB); press(START);
      repeat (150) step();
      chk("t3_remain45", int'(bus.remain_sec), 45);
      bus.door_open = 1'b1; step();
      chk("t3_pause", int'(bus.state), 2);
      chk("t3_pause_run", int'(bus.run), 0);
      chk("t3_hold45", int'(bus.remain_sec), 45);
      press(START);
      chk("t3_start_door_open", int'(bus.state), 2);
      bus.door_open = 1'b0; step();
      press(START);
      chk("t3_resume", int'(bus.state), 1);
      repeat (9) step();
      chk("t3_no_dec_yet", int'(bus.remain_sec), 45);
      step();
      chk("t3_first_dec", int'(bus.remain_sec), 44);

      // Add coincident with the final tick keeps cooking.
      repeat (430) step();
      chk("t4_remain1", int'(bus.remain_sec), 1);
      repeat (9) step();
      press(ADDB);
      chk("t4_remain30", int'(bus.remain_sec), 30);
      chk("t4_still_run", int'(bus.state), 1);
      chk("t4_no_beep", int'(bus.done_beep), 0);

      // Stop in pause, door during done.
      bus.door_open = 1'b1; step();
      bus.door_open = 1'b0;
      press(STOP);
      chk("t5_stop_idle", int'(bus.state), 0);
      chk("t5_stop_clear", int'(bus.remain_sec), 0);
      press(ADDB); press(START);
      repeat (300) step();
      chk("t5_done", int'(bus.state), 3);
      step();
      bus.door_open = 1'b1; step();
      chk("t5_door_idle", int'(bus.state), 0);
      chk("t5_door_beep", int'(bus.done_beep), 0);
      bus.door_open = 1'b0;

      // Reset mid-run and reset held across a start pulse.
      press(ADDB); press(START);
      repeat (100) step();
      chk("t6_remain20", int'(bus.remain_sec), 20);
      rst = 1'b1; step();
      chk("t6_rst_state", int'(bus.state), 0);
      chk("t6_rst_run", int'(bus.run), 0);
      chk("t6_rst_remain", int'(bus.remain_sec), 0);
      chk("t6_rst_beep", int'(bus.done_beep), 0);
      press(ADDB); press(START);
      chk("t6_rst_hold_state", int'(bus.state), 0);
      chk("t6_rst_hold_remain", int'(bus.remain_sec), 0);
      rst = 1'b0;

      // Random buttons, door and occasional reset.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 99) < 2) bus.door_open = ~bus.door_open;
         bus.btn_add   = ($urandom_range(0, 99) < 6);
         bus.btn_start = ($urandom_range(0, 99) < 5);
         bus.btn_stop  = ($urandom_range(0, 99) < 2);
         rst           = ($urandom_range(0, 999) < 3);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cook_timer_fsm.md
Name: cook_timer_fsm

Overview:
Microwave cook sequencer that sits directly upstream of the magnetron/turntable motor PWM stage and drives that stage's `run` input. It holds the remaining cook time in seconds, takes start/stop/add-time button pulses and the door interlock, and counts down once per second. It also drives a completion beep enable and exposes the remaining time and state for the display path.

Parameters:
TICK_DIV, 100000000, clk cycles per cook second (1 s at 100 MHz); must be >= 2
ADD_SEC, 30, seconds added per btn_add pulse
MAX_SEC, 5999, saturation ceiling for remaining time (99:59)
DONE_SEC, 3, seconds done_beep stays high after completion

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_start  in  1  single-cycle pulse (already debounced/edge-detected)
btn_stop  in  1  single-cycle pulse
btn_add  in  1  single-cycle pulse
door_open  in  1  level; 1 = door open (interlock)
run  out  1  enable to motor PWM stage
done_beep  out  1  buzzer enable
remain_sec  out  13  remaining cook seconds, 0..MAX_SEC
state  out  2  0=IDLE 1=RUN 2=PAUSE 3=DONE

Behaviour:
- Single clk domain. All state changes happen on posedge clk. rst is sampled on the clock edge.
- Reset values: state=IDLE, remain_sec=0, run=0, done_beep=0, prescaler=0, beep second count=0. Reset mid-RUN drops run on the next edge.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and DONE. It is forced to 0 in IDLE and PAUSE and on every state transition. sec_tick is 1 when prescaler==TICK_DIV-1 (the wrap cycle). The first tick therefore arrives exactly TICK_DIV cycles after entering RUN or DONE.
- Add rule: remain_sec <= min(remain_sec + ADD_SEC, MAX_SEC). Compute the sum in 14 bits, with no wrap.
- Per-cycle event priority: door_open > btn_stop > btn_start > sec_tick/btn_add.
- IDLE:
  - btn_stop clears remain_sec to 0.
  - btn_add applies the add rule.
  - btn_start with remain_sec>0 and door_open=0 goes to RUN.
  - btn_start with remain_sec==0 or door open is ignored.
- RUN:
  - door_open=1 or btn_stop goes to PAUSE; remain_sec is held and any same-cycle tick is discarded.
  - On sec_tick with btn_add in the same cycle: remain_sec <= min(remain_sec-1+ADD_SEC, MAX_SEC), and the block stays in RUN.
  - On sec_tick alone: if remain_sec==1, then remain_sec <= 0 and go to DONE; otherwise decrement.
  - btn_add alone applies the add rule.
  - btn_start has no effect.
- PAUSE:
  - btn_stop clears remain_sec and goes to IDLE.
  - btn_start with door_open=0 goes to RUN.
  - btn_add applies the add rule.
- DONE:
  - done_beep=1.
  - Count sec_ticks. After DONE_SEC ticks, go to IDLE with done_beep=0.
  - door_open or btn_stop goes to IDLE immediately.
  - btn_start and btn_add are ignored.
- Outputs are registered:
  - run=1 iff the registered state is RUN and the door is closed. Derive run from next_state so that run rises in the same edge that enters RUN.
  - Latency: start pulse in cycle N gives state=RUN and run=1 from cycle N+1.
  - door_open rising in cycle N gives run=0 and state=PAUSE from cycle N+1.
  - The final tick in cycle N gives run=0, done_beep=1 and state=DONE from cycle N+1.
- Invariants:
  - run never 1 while state!=RUN.
  - remain_sec never exceeds MAX_SEC.
  - remain_sec never underflows: RUN is never entered with remain_sec=0.

Test Plan (TICK_DIV=10, ADD_SEC=30, MAX_SEC=90, DONE_SEC=2):
1. Reset, then 2x btn_add, then btn_start -> remain_sec=60 and run=1 the next cycle. After 10 cycles remain_sec=59. After 600 cycles in RUN: state=DONE, run=0, done_beep=1 for 20 cycles, then IDLE with remain_sec=0.
2. 4x btn_add in IDLE -> remain_sec=30,60,90,90 (saturation). btn_start with remain_sec=0 after a btn_stop -> state stays IDLE and run stays 0.
3. RUN with remain_sec=45, door_open=1 -> next cycle state=PAUSE, run=0, remain_sec=45 held. btn_start while door still open -> ignored. Door closed then btn_start -> RUN, first decrement exactly 10 cycles later.
4. RUN with remain_sec=1, btn_add coincident with sec_tick -> remain_sec=30, state remains RUN, done_beep stays 0.
5. btn_stop in PAUSE -> IDLE, remain_sec=0. Door opened during DONE -> IDLE and done_beep=0 the next cycle.
6. rst asserted mid-RUN (remain_sec=20) -> next edge: state=IDLE, run=0, remain_sec=0, done_beep=0. rst held over a btn_start pulse -> no transition.
